// File: rtl/logic_op_pipe.sv
`default_nettype none
// logic_op_pipe: two-stage issue/retire wrapper around the 32-bit AND/OR/XOR logic unit.
// Rev 1.0

module unit_L #(
  parameter int WIDTH = 32
) (
  input  logic             f1,
  input  logic             f0,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case ({f1, f0})
      2'b01:   y = a & b;
      2'b10:   y = a | b;
      2'b11:   y = a ^ b;
      default: y = '0;
    endcase
  end
endmodule

module logic_op_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_use_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic             s1_use_acc;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_neg;
  logic             s2_parity;
  logic             s2_illegal;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_y;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign pop      = s2_valid && out_ready;

  // The stage-2 result register doubles as the accumulator; the preceding op
  // is always in stage 2 by the time a chained op leaves stage 1.
  assign unit_a = s1_use_acc ? s2_result : s1_a;

  unit_L #(.WIDTH(WIDTH)) u_unit (
    .f1 (s1_op[1]),
    .f0 (s1_op[0]),
    .a  (unit_a),
    .b  (s1_b),
    .y  (unit_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_op      <= 2'b00;
      s1_use_acc <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_op      <= in_op;
        s1_use_acc <= in_use_acc;
        s1_a       <= in_a;
        s1_b       <= in_b;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_zero    <= 1'b0;
      s2_neg     <= 1'b0;
      s2_parity  <= 1'b0;
      s2_illegal <= 1'b0;
    end else begin
      if (s1_adv) begin
        s2_valid   <= 1'b1;
        s2_result  <= unit_y;
        s2_zero    <= (unit_y == '0);
        s2_neg     <= unit_y[WIDTH-1];
        s2_parity  <= ^unit_y;
        s2_illegal <= (s1_op == 2'b00);
      end else if (pop) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (pop) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_zero    = s2_zero;
  assign out_neg     = s2_neg;
  assign out_parity  = s2_parity;
  assign out_illegal = s2_illegal;

endmodule
`default_nettype wire

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Pipelined issue/retire stage wrapped around the 32-bit logic unit (`unit_L`: AND/OR/XOR).
- Accepts operations over a valid/ready handshake and registers the operands.
- Drives the logic unit's f1/f0/a/b inputs from that operand register, then captures the unit's output into a result register with status flags.
- Presents the result downstream over a second valid/ready handshake; also provides an accumulator-chaining mode and a retired-op counter.

Parameters:
- WIDTH, 32, operand/result width; must match the logic unit width.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  block can accept an operation this cycle.
- in_op  input  2  {f1,f0}: 01 AND, 10 OR, 11 XOR, 00 illegal.
- in_use_acc  input  1  when 1, operand a is replaced by the accumulator.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  logic result.
- out_zero  output  1  result == 0.
- out_neg  output  1  result[WIDTH-1].
- out_parity  output  1  XOR-reduction of the result.
- out_illegal  output  1  op was 00; result forced to 0.
- op_count  output  CNT_W  number of results retired.

Behaviour:
- Reset (async, rst=1): all registers clear.
  - s1_valid=0, s2_valid=0, all operand/result/flag registers = 0, op_count=0.
  - Outputs during reset: in_ready=1, out_valid=0, out_result=0, all flags=0.
- Stage 1 (issue register): holds op, use_acc, a, b.
  - Drives the logic unit: f1=op[1], f0=op[0], a=(use_acc ? acc : s1_a), b=s1_b.
- Stage 2 (result register): captures the logic unit output plus flags.
  - acc is the stage-2 result register itself. It keeps the last captured result after it is popped.
- Handshake and advance rules:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational; it must not depend on in_valid.
  - Input accept when in_valid && in_ready: stage 1 loads at that edge.
  - Stage 2 loads on s1_adv. s1_valid clears on s1_adv unless a new accept happens in the same cycle.
  - out_valid = s2_valid. s2_valid clears on out_valid && out_ready && !s1_adv.
- Latency: accept at edge N gives out_valid high after edge N+1 (2-cycle minimum).
  - Full throughput is 1 op/cycle with out_ready held high.
- Backpressure: while out_ready=0 and both stages are full, in_ready=0.
  - out_result and flags stay stable while out_valid && !out_ready.
  - Stage 1 operands must not change while s1_valid && !s1_adv.
- Accumulator chaining: an op with use_acc=1 uses the result of the immediately preceding op.
  - The preceding op enters stage 2 no later than this op leaves stage 1, so no stall or forwarding is needed.
  - After reset, acc=0.
- Illegal op (00): the logic unit already outputs 0.
  - Result = 0, out_zero=1, out_illegal=1. The op still retires and counts.
- Flags are computed from the captured result at stage-2 load, not from in-flight data.
- op_count increments by 1 on each out_valid && out_ready and wraps modulo 2^CNT_W (0xFFFF -> 0x0000).
- Simultaneous pop and push on a full pipe: both happen in the same cycle, with no bubble.
- Reset asserted mid-operation: any in-flight ops are discarded, no partial output appears, and the counter clears.

Test Plan:
- Single ops, a=0xDC754CD2, b=0x4124F055, out_ready=1:
  - op=01 -> out_result=0x40244050, zero=0, neg=0.
  - op=10 -> 0xDD75FCD7, neg=1.
  - op=11 -> 0x9D51BC87, parity=1.
  - Each result appears 2 cycles after accept.
- Chain: XOR above, then op=01, use_acc=1, b=0xFFFF0000 -> 0x9D510000, neg=1, back-to-back without stall.
- Illegal: op=00, a=b=0xFFFFFFFF -> out_result=0, zero=1, illegal=1, op_count increments.
- Backpressure: hold out_ready=0 and push 3 ops.
  - 2 are accepted, then in_ready=0 and the first result stays stable.
  - Release out_ready -> results retire in order, 1 per cycle.
- Streaming with out_ready=1 for 10 ops -> 10 results in order, in_ready never drops, op_count=10.
- Reset mid-stream with both stages full -> out_valid=0, op_count=0, in_ready=1 immediately; the next op yields a correct result.
